// File: rtl/fwd_hazard_ctrl.sv
// Operand-select and load-use hazard control for a 4-stage (ID/EX/MEM/WB) pipeline.
// Tracks EX/MEM destinations, registers the EX operand mux codes, and stalls on load-use.
module fwd_hazard_ctrl #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             id_valid,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_use_rs1,
    input  logic             id_use_rs2,
    input  logic             id_a_pc,
    input  logic             id_b_imm,
    input  logic [4:0]       id_rd,
    input  logic             id_reg_we,
    input  logic             id_is_load,
    input  logic             hold,
    input  logic             flush,
    output logic             stall,
    output logic             ex_valid,
    output logic [1:0]       a_sel,
    output logic [1:0]       b_sel,
    output logic [CNT_W-1:0] stall_cnt
);

    logic             ex_valid_q, ex_valid_d;
    logic [4:0]       ex_rd_q, ex_rd_d;
    logic             ex_we_q, ex_we_d;
    logic             ex_load_q, ex_load_d;
    logic             mem_valid_q, mem_valid_d;
    logic [4:0]       mem_rd_q, mem_rd_d;
    logic             mem_we_q, mem_we_d;
    logic [1:0]       a_sel_q, a_sel_d;
    logic [1:0]       b_sel_q, b_sel_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    logic       a_hit_e, a_hit_m, b_hit_e, b_hit_m;
    logic       load_hit_a, load_hit_b;
    logic       bubble;
    logic [1:0] a_sel_nxt, b_sel_nxt;

    // x0 never matches, so it is neither forwarded nor stalled on.
    assign a_hit_e = ex_valid_q  & ex_we_q  & (ex_rd_q  == id_rs1) & (id_rs1 != 5'd0);
    assign a_hit_m = mem_valid_q & mem_we_q & (mem_rd_q == id_rs1) & (id_rs1 != 5'd0);
    assign b_hit_e = ex_valid_q  & ex_we_q  & (ex_rd_q  == id_rs2) & (id_rs2 != 5'd0);
    assign b_hit_m = mem_valid_q & mem_we_q & (mem_rd_q == id_rs2) & (id_rs2 != 5'd0);

    assign load_hit_a = id_use_rs1 & ~id_a_pc  & (ex_rd_q == id_rs1);
    assign load_hit_b = id_use_rs2 & ~id_b_imm & (ex_rd_q == id_rs2);

    assign stall = id_valid & ~flush & ex_valid_q & ex_load_q & ex_we_q & (ex_rd_q != 5'd0)
                 & (load_hit_a | load_hit_b);

    assign bubble = stall | flush;

    always_comb begin
        a_sel_nxt = 2'd0;
        if (id_a_pc)                      a_sel_nxt = 2'd1;
        else if (id_use_rs1 && a_hit_e)   a_sel_nxt = 2'd2;
        else if (id_use_rs1 && a_hit_m)   a_sel_nxt = 2'd3;

        b_sel_nxt = 2'd0;
        if (id_b_imm)                     b_sel_nxt = 2'd1;
        else if (id_use_rs2 && b_hit_e)   b_sel_nxt = 2'd2;
        else if (id_use_rs2 && b_hit_m)   b_sel_nxt = 2'd3;
    end

    always_comb begin
        ex_valid_d  = ex_valid_q;
        ex_rd_d     = ex_rd_q;
        ex_we_d     = ex_we_q;
        ex_load_d   = ex_load_q;
        mem_valid_d = mem_valid_q;
        mem_rd_d    = mem_rd_q;
        mem_we_d    = mem_we_q;
        a_sel_d     = a_sel_q;
        b_sel_d     = b_sel_q;
        stall_cnt_d = stall_cnt_q;
        if (!hold) begin
            mem_valid_d = ex_valid_q;
            mem_rd_d    = ex_rd_q;
            mem_we_d    = ex_we_q;
            ex_rd_d     = id_rd;
            ex_valid_d  = id_valid & ~bubble;
            ex_we_d     = id_valid & id_reg_we & ~bubble;
            ex_load_d   = id_valid & id_is_load & ~bubble;
            a_sel_d     = bubble ? 2'd0 : a_sel_nxt;
            b_sel_d     = bubble ? 2'd0 : b_sel_nxt;
            if (stall && (stall_cnt_q != {CNT_W{1'b1}}))
                stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid_q  <= 1'b0;
            ex_rd_q     <= 5'd0;
            ex_we_q     <= 1'b0;
            ex_load_q   <= 1'b0;
            mem_valid_q <= 1'b0;
            mem_rd_q    <= 5'd0;
            mem_we_q    <= 1'b0;
            a_sel_q     <= 2'd0;
            b_sel_q     <= 2'd0;
            stall_cnt_q <= '0;
        end else begin
            ex_valid_q  <= ex_valid_d;
            ex_rd_q     <= ex_rd_d;
            ex_we_q     <= ex_we_d;
            ex_load_q   <= ex_load_d;
            mem_valid_q <= mem_valid_d;
            mem_rd_q    <= mem_rd_d;
            mem_we_q    <= mem_we_d;
            a_sel_q     <= a_sel_d;
            b_sel_q     <= b_sel_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign ex_valid  = ex_valid_q;
    assign a_sel     = a_sel_q;
    assign b_sel     = b_sel_q;
    assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// Directed bench for fwd_hazard_ctrl: forwarding codes, load-use stall, flush, hold, saturation.
module tb_fwd_hazard_ctrl;

    localparam int CNT_W = 2;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             id_valid = 1'b0;
    logic [4:0]       id_rs1 = '0, id_rs2 = '0, id_rd = '0;
    logic             id_use_rs1 = 1'b0, id_use_rs2 = 1'b0;
    logic             id_a_pc = 1'b0, id_b_imm = 1'b0;
    logic             id_reg_we = 1'b0, id_is_load = 1'b0;
    logic             hold = 1'b0, flush = 1'b0;
    logic             stall, ex_valid;
    logic [1:0]       a_sel, b_sel;
    logic [CNT_W-1:0] stall_cnt;

    int n_chk  = 0;
    int n_pass = 0;
    int exp_cnt = 0;

    fwd_hazard_ctrl #(.CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .id_a_pc(id_a_pc), .id_b_imm(id_b_imm),
        .id_rd(id_rd), .id_reg_we(id_reg_we), .id_is_load(id_is_load),
        .hold(hold), .flush(flush),
        .stall(stall), .ex_valid(ex_valid),
        .a_sel(a_sel), .b_sel(b_sel), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive the ID stage: valid, rs1, rs2, use1, use2, a_pc, b_imm, rd, we, load
    task automatic drv(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic u1, input logic u2, input logic apc, input logic bimm,
                       input logic [4:0] rd, input logic we, input logic ld);
        id_valid = v; id_rs1 = rs1; id_rs2 = rs2; id_use_rs1 = u1; id_use_rs2 = u2;
        id_a_pc = apc; id_b_imm = bimm; id_rd = rd; id_reg_we = we; id_is_load = ld;
        #1;
    endtask

    task automatic clear_pipe();
        drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        tick();
    endtask

    task automatic test_reset_init();
        n_chk++;
        if ({ex_valid, a_sel, b_sel, stall_cnt} !== '0)
            $display("FAIL reset_init: got ex_valid=%0b a=%0d b=%0d cnt=%0d exp all 0",
                     ex_valid, a_sel, b_sel, stall_cnt);
        else n_pass++;
    endtask

    task automatic test_alu_fwd();
        clear_pipe();
        drv(1, 1, 0, 1, 0, 0, 1, 5, 1, 0);          // addi x5,x1,imm
        tick();
        n_chk++;
        if (ex_valid !== 1'b1 || a_sel !== 2'd0 || b_sel !== 2'd1)
            $display("FAIL addi_enter: got v=%0b a=%0d b=%0d exp v=1 a=0 b=1", ex_valid, a_sel, b_sel);
        else n_pass++;
        drv(1, 5, 7, 1, 1, 0, 0, 6, 1, 0);          // add x6,x5,x7
        n_chk++;
        if (stall !== 1'b0) $display("FAIL alu_no_stall: got %0b exp 0", stall);
        else n_pass++;
        tick();
        n_chk++;
        if (a_sel !== 2'd2 || b_sel !== 2'd0)
            $display("FAIL fwd_ex: got a=%0d b=%0d exp a=2 b=0", a_sel, b_sel);
        else n_pass++;
        drv(1, 1, 0, 1, 0, 0, 1, 9, 1, 0);          // addi x9,x1,imm
        tick();
        drv(1, 2, 0, 1, 0, 0, 1, 10, 1, 0);         // addi x10,x2,imm
        tick();
        drv(1, 9, 10, 1, 1, 0, 0, 11, 1, 0);        // add x11,x9,x10
        tick();
        n_chk++;
        if (a_sel !== 2'd3 || b_sel !== 2'd2)
            $display("FAIL fwd_mem_ex: got a=%0d b=%0d exp a=3 b=2", a_sel, b_sel);
        else n_pass++;
        drv(1, 9, 1, 1, 1, 0, 0, 12, 1, 0);         // x9 now in WB: write-through
        tick();
        n_chk++;
        if (a_sel !== 2'd0 || b_sel !== 2'd0)
            $display("FAIL wb_no_fwd: got a=%0d b=%0d exp a=0 b=0", a_sel, b_sel);
        else n_pass++;
    endtask

    task automatic test_load_use();
        clear_pipe();
        drv(1, 2, 0, 1, 0, 0, 1, 5, 1, 1);          // lw x5,0(x2)
        tick();
        drv(1, 0, 5, 1, 1, 0, 0, 6, 1, 0);          // add x6,x0,x5
        n_chk++;
        if (stall !== 1'b1) $display("FAIL lu_stall: got %0b exp 1", stall);
        else n_pass++;
        tick();
        exp_cnt = (exp_cnt == 3) ? 3 : exp_cnt + 1;
        n_chk++;
        if (ex_valid !== 1'b0 || stall !== 1'b0 || stall_cnt !== exp_cnt[CNT_W-1:0])
            $display("FAIL lu_bubble: got v=%0b stall=%0b cnt=%0d exp v=0 stall=0 cnt=%0d",
                     ex_valid, stall, stall_cnt, exp_cnt);
        else n_pass++;
        tick();
        n_chk++;
        if (ex_valid !== 1'b1 || a_sel !== 2'd0 || b_sel !== 2'd3)
            $display("FAIL lu_resolve: got v=%0b a=%0d b=%0d exp v=1 a=0 b=3", ex_valid, a_sel, b_sel);
        else n_pass++;
    endtask

    task automatic test_x0_priority();
        clear_pipe();
        drv(1, 2, 0, 1, 0, 0, 1, 0, 1, 1);          // lw x0
        tick();
        drv(1, 0, 0, 1, 1, 0, 0, 6, 1, 0);          // add x6,x0,x0
        n_chk++;
        if (stall !== 1'b0) $display("FAIL x0_no_stall: got %0b exp 0", stall);
        else n_pass++;
        tick();
        n_chk++;
        if (a_sel !== 2'd0 || b_sel !== 2'd0)
            $display("FAIL x0_no_fwd: got a=%0d b=%0d exp a=0 b=0", a_sel, b_sel);
        else n_pass++;
        drv(1, 1, 0, 1, 0, 0, 1, 5, 1, 0);          // addi x5 (older)
        tick();
        drv(1, 1, 0, 1, 0, 0, 1, 5, 1, 0);          // addi x5 (younger)
        tick();
        drv(1, 5, 5, 1, 1, 0, 0, 6, 1, 0);          // add x6,x5,x5
        tick();
        n_chk++;
        if (a_sel !== 2'd2 || b_sel !== 2'd2)
            $display("FAIL youngest_wins: got a=%0d b=%0d exp a=2 b=2", a_sel, b_sel);
        else n_pass++;
        drv(1, 6, 6, 1, 1, 1, 1, 7, 1, 0);          // pc/imm override a hit on x6
        tick();
        n_chk++;
        if (a_sel !== 2'd1 || b_sel !== 2'd1)
            $display("FAIL pc_imm_sel: got a=%0d b=%0d exp a=1 b=1", a_sel, b_sel);
        else n_pass++;
    endtask

    task automatic test_flush();
        clear_pipe();
        drv(1, 2, 0, 1, 0, 0, 1, 5, 1, 1);          // lw x5
        tick();
        drv(1, 5, 1, 1, 1, 0, 0, 6, 1, 0);          // add x6,x5,x1
        flush = 1'b1;
        #1;
        n_chk++;
        if (stall !== 1'b0) $display("FAIL flush_no_stall: got %0b exp 0", stall);
        else n_pass++;
        tick();
        flush = 1'b0;
        n_chk++;
        if (ex_valid !== 1'b0 || a_sel !== 2'd0 || stall_cnt !== exp_cnt[CNT_W-1:0])
            $display("FAIL flush_bubble: got v=%0b a=%0d cnt=%0d exp v=0 a=0 cnt=%0d",
                     ex_valid, a_sel, stall_cnt, exp_cnt);
        else n_pass++;
        drv(1, 5, 0, 1, 0, 0, 1, 7, 1, 0);          // lw survived flush in MEM
        tick();
        n_chk++;
        if (a_sel !== 2'd3) $display("FAIL flush_keeps_mem: got a=%0d exp 3", a_sel);
        else n_pass++;
    endtask

    task automatic test_hold();
        clear_pipe();
        drv(1, 2, 0, 1, 0, 0, 1, 5, 1, 1);          // lw x5
        tick();
        drv(1, 5, 1, 1, 1, 0, 0, 6, 1, 0);          // add x6,x5,x1
        hold = 1'b1;
        #1;
        for (int i = 0; i < 2; i++) begin
            tick();
            n_chk++;
            if (stall !== 1'b1 || ex_valid !== 1'b1 || a_sel !== 2'd0 || b_sel !== 2'd1 ||
                stall_cnt !== exp_cnt[CNT_W-1:0])
                $display("FAIL hold_frozen: cyc=%0d got stall=%0b v=%0b a=%0d b=%0d cnt=%0d exp 1 1 0 1 %0d",
                         i, stall, ex_valid, a_sel, b_sel, stall_cnt, exp_cnt);
            else n_pass++;
        end
        hold = 1'b0;
        tick();
        exp_cnt = (exp_cnt == 3) ? 3 : exp_cnt + 1;
        n_chk++;
        if (ex_valid !== 1'b0 || stall_cnt !== exp_cnt[CNT_W-1:0])
            $display("FAIL hold_release: got v=%0b cnt=%0d exp v=0 cnt=%0d", ex_valid, stall_cnt, exp_cnt);
        else n_pass++;
        tick();
        n_chk++;
        if (a_sel !== 2'd3 || b_sel !== 2'd0)
            $display("FAIL hold_resolve: got a=%0d b=%0d exp a=3 b=0", a_sel, b_sel);
        else n_pass++;
    endtask

    task automatic test_reset_midrun();
        drv(1, 1, 0, 1, 0, 1, 1, 4, 1, 0);          // auipc-like: a=1 b=1
        tick();
        n_chk++;
        if (ex_valid !== 1'b1 || stall_cnt === '0)
            $display("FAIL pre_reset: got v=%0b cnt=%0d exp v=1 cnt!=0", ex_valid, stall_cnt);
        else n_pass++;
        #2;
        rst_n = 1'b0;
        #1;
        n_chk++;
        if ({ex_valid, a_sel, b_sel, stall_cnt} !== '0)
            $display("FAIL async_reset: got v=%0b a=%0d b=%0d cnt=%0d exp all 0",
                     ex_valid, a_sel, b_sel, stall_cnt);
        else n_pass++;
        exp_cnt = 0;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_saturation();
        for (int k = 0; k < 4; k++) begin
            clear_pipe();
            drv(1, 2, 0, 1, 0, 0, 1, 8, 1, 1);      // lw x8
            tick();
            drv(1, 8, 0, 1, 0, 0, 1, 9, 1, 0);      // addi x9,x8,imm
            tick();
            exp_cnt = (exp_cnt == 3) ? 3 : exp_cnt + 1;
            n_chk++;
            if (stall_cnt !== exp_cnt[CNT_W-1:0])
                $display("FAIL sat_cnt: stall=%0d got %0d exp %0d", k, stall_cnt, exp_cnt);
            else n_pass++;
        end
    endtask

    initial begin
        #2;
        test_reset_init();
        tick();
        rst_n = 1'b1;
        test_alu_fwd();
        test_load_use();
        test_x0_priority();
        test_flush();
        test_hold();
        test_reset_midrun();
        test_saturation();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
